// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
package fetch_unit_pkg;

    // Fetch sequencing: issue a request, wait for its data, then present it to decode.
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    // addi x0, x0, 0 -- what decode sees before the first real fetch.
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, keeps at most one memory request in flight,
// and hands each fetched word to decode. A redirect squashes any fetch in flight.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         drop_q, drop_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic [31:0]  instr_pc_plus4_q, instr_pc_plus4_d;
    logic         req_valid_q, req_valid_d;
    logic         instr_valid_q, instr_valid_d;

    logic [31:0]  pc_plus4;
    logic [31:0]  redirect_target;
    logic         req_accept;

    assign pc_plus4        = pc_q + 32'd4;
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    // req_valid_q is low only in the single REQ cycle right after reset.
    assign req_accept      = req_valid_q & imem_req_ready;

    // Next-state logic: redirect overrides every other event in every state.
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        drop_d           = drop_q;
        instr_d          = instr_q;
        instr_pc_d       = instr_pc_q;
        instr_pc_plus4_d = instr_pc_plus4_q;
        case (state_q)
            REQ: begin
                if (req_accept) begin
                    state_d = WAIT;
                end
                if (redirect_valid) begin
                    pc_d   = redirect_target;
                    // A request accepted this same cycle is already wrong-path.
                    drop_d = req_accept;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                    if (imem_rsp_valid) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        instr_d          = imem_rsp_data;
                        instr_pc_d       = pc_q;
                        instr_pc_plus4_d = pc_plus4;
                        pc_d             = pc_plus4;
                        state_d          = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = REQ;
                end else if (instr_ready) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase
        req_valid_d   = (state_d == REQ);
        instr_valid_d = (state_d == HOLD);
    end

    // State and registered outputs; reset parks in REQ with no request asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= REQ;
            pc_q             <= RESET_PC;
            drop_q           <= 1'b0;
            instr_q          <= NOP_INSTR;
            instr_pc_q       <= RESET_PC;
            instr_pc_plus4_q <= RESET_PC + 32'd4;
            req_valid_q      <= 1'b0;
            instr_valid_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            drop_q           <= drop_d;
            instr_q          <= instr_d;
            instr_pc_q       <= instr_pc_d;
            instr_pc_plus4_q <= instr_pc_plus4_d;
            req_valid_q      <= req_valid_d;
            instr_valid_q    <= instr_valid_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign instr_pc_plus4 = instr_pc_plus4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a memory model with variable latency and a
// program-order scoreboard predicting every request address and delivered word.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'd0;
    logic        instr_valid;
    logic        instr_ready    = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus knobs (percent probabilities and memory latency range).
    int p_rdy = 100, p_irdy = 0, p_redir = 0, min_lat = 1, max_lat = 1;

    // Reference model: program order plus a single-slot memory.
    logic [31:0] exp_req = RPC;
    logic [31:0] exp_pc  = RPC;
    bit          mem_pend = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = 32'd0;
    int          cyc = 0, acc_cyc = 0, acc_lat = 0, delivered = 0;
    bit          redir_since_acc = 1'b1;
    bit          prev_iv = 1'b0, prev_redir = 1'b0, prev_hs = 1'b0;
    bit          ok;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h0050_0093;
        return (a * 32'h0001_0003) ^ 32'h5A5A_0013;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] r;
        r = $urandom;
        if (r[31:29] == 3'b111) return 32'hFFFF_FFF0 | {28'd0, r[3:0]};
        return {22'd0, r[9:0]};
    endfunction

    // One clock cycle: called at a falling edge, drives inputs, checks outputs,
    // advances the model, and returns at the next falling edge.
    task automatic step(input bit fr, input logic [31:0] ft);
        bit          redir, hs, accept;
        logic [31:0] tgt;
        cyc++;
        if (imem_req_valid) check32("one_outstanding", {31'd0, mem_pend}, 32'd0);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_addr);
                mem_pend       = 1'b0;
            end
        end
        redir          = fr || ($urandom_range(0, 99) < p_redir);
        tgt            = fr ? ft : rand_target();
        redirect_valid = redir;
        redirect_pc    = tgt;
        imem_req_ready = ($urandom_range(0, 99) < p_rdy);
        instr_ready    = ($urandom_range(0, 99) < p_irdy);

        if (prev_redir || prev_hs) check32("valid_drop", {31'd0, instr_valid}, 32'd0);
        if (imem_req_valid) check32("req_addr", imem_req_addr, exp_req);
        if (instr_valid) begin
            check32("instr_pc", instr_pc, exp_pc);
            check32("instr", instr, mem_word(exp_pc));
            check32("instr_pc_plus4", instr_pc_plus4, exp_pc + 32'd4);
            if (!prev_iv && !redir_since_acc && acc_lat == 1)
                check32("min_latency", 32'(cyc - acc_cyc), 32'd2);
        end

        accept = imem_req_valid && imem_req_ready;
        if (accept) begin
            mem_pend        = 1'b1;
            mem_cnt         = $urandom_range(min_lat, max_lat);
            mem_addr        = imem_req_addr;
            acc_cyc         = cyc;
            acc_lat         = mem_cnt;
            redir_since_acc = 1'b0;
            exp_req         = exp_req + 32'd4;
        end
        hs = instr_valid && instr_ready && !redir;
        if (hs) begin
            delivered++;
            $display("XFER pc=%08h instr=%08h cycle=%0d", instr_pc, instr, cyc);
            exp_pc = exp_pc + 32'd4;
        end
        if (redir) begin
            exp_req         = tgt & 32'hFFFF_FFFC;
            exp_pc          = tgt & 32'hFFFF_FFFC;
            redir_since_acc = 1'b1;
            $display("REDIRECT to %08h cycle=%0d", tgt, cyc);
        end
        prev_iv    = instr_valid;
        prev_redir = redir;
        prev_hs    = hs;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check32("rst_req_addr", imem_req_addr, RPC);
        check32("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check32("rst_instr", instr, NOP_INSTR);
        check32("rst_instr_pc", instr_pc, RPC);
        check32("rst_instr_pc_plus4", instr_pc_plus4, RPC + 32'd4);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check32("first_req_valid", {31'd0, imem_req_valid}, 32'd1);

        // First fetch with zero-wait memory, then 5+ cycles of decode backpressure.
        p_rdy = 100; p_irdy = 0; p_redir = 0; min_lat = 1; max_lat = 1;
        repeat (8) step(1'b0, 32'd0);
        check32("bp_held_valid", {31'd0, instr_valid}, 32'd1);
        p_irdy = 100;
        repeat (8) step(1'b0, 32'd0);

        // Redirect while waiting with no response this cycle.
        min_lat = 3; max_lat = 3; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_pend && mem_cnt == 3) begin ok = 1'b1; break; end
            step(1'b0, 32'd0);
        end
        check32("reach_wait", {31'd0, ok}, 32'd1);
        step(1'b1, 32'h0000_0102);
        repeat (12) step(1'b0, 32'd0);

        // Redirect coincident with the response.
        min_lat = 1; max_lat = 1; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_pend && mem_cnt == 1) begin ok = 1'b1; break; end
            step(1'b0, 32'd0);
        end
        check32("reach_rsp", {31'd0, ok}, 32'd1);
        step(1'b1, 32'h0000_0200);
        repeat (10) step(1'b0, 32'd0);

        // Redirect coincident with request acceptance.
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req_valid && !mem_pend) begin ok = 1'b1; break; end
            step(1'b0, 32'd0);
        end
        check32("reach_req", {31'd0, ok}, 32'd1);
        step(1'b1, 32'h0000_0300);
        repeat (10) step(1'b0, 32'd0);

        // PC wrap from the top of the address space.
        step(1'b1, 32'hFFFF_FFFC);
        repeat (12) step(1'b0, 32'd0);

        // Random traffic.
        p_rdy = 70; p_irdy = 60; p_redir = 6; min_lat = 1; max_lat = 3;
        repeat (3000) step(1'b0, 32'd0);

        // Reset while a fetch is outstanding.
        p_redir = 0; p_rdy = 100; p_irdy = 100; min_lat = 3; max_lat = 3; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_pend) begin ok = 1'b1; break; end
            step(1'b0, 32'd0);
        end
        check32("reach_wait_rst", {31'd0, ok}, 32'd1);
        rst = 1'b1;
        redirect_valid = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b0; instr_ready = 1'b0;
        mem_pend = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check32("midrst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check32("midrst_instr", instr, NOP_INSTR);
        check32("midrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check32("midrst_req_addr", imem_req_addr, RPC);
        rst = 1'b0;
        exp_req = RPC; exp_pc = RPC; acc_lat = 0; redir_since_acc = 1'b1;
        prev_iv = 1'b0; prev_redir = 1'b0; prev_hs = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check32("midrst_first_req", {31'd0, imem_req_valid}, 32'd1);
        min_lat = 1; max_lat = 1;
        repeat (12) step(1'b0, 32'd0);

        check32("liveness", {31'd0, (delivered >= 100)}, 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
